// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: fetch port, load/store port and memory port.
// master = arbiter side, slave = pipeline/memory side.
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        timeout;

  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ack, ls_rdata, ls_ack, mem_req, mem_we, mem_addr, mem_wdata, timeout
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ack, ls_rdata, ls_ack, mem_req, mem_we, mem_addr, mem_wdata, timeout
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory port arbiter (load/store priority, fetch fairness, timeout).
// Define ARB_PERF_COUNTERS_EN to add grant and stall performance counters.
module mem_bus_arbiter #(
  parameter int unsigned MAX_LS_STREAK  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
`ifdef ARB_PERF_COUNTERS_EN
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_ls_grants,
  output logic [31:0] perf_stall_cycles,
`endif
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       owner_ls;
  logic [3:0] streak;
  logic [7:0] tcnt;
  logic       ls_win;
  logic       if_win;

  always_comb begin
    ls_win = 1'b0;
    if_win = 1'b0;
    if (state == IDLE) begin
      ls_win = bus.ls_req && !(bus.if_req && streak == STREAK_MAX);
      if_win = !ls_win && bus.if_req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner_ls      <= 1'b0;
      streak        <= '0;
      tcnt          <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.if_ack    <= 1'b0;
      bus.ls_rdata  <= '0;
      bus.ls_ack    <= 1'b0;
      bus.timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (ls_win) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.ls_we;
            bus.mem_addr  <= bus.ls_addr;
            bus.mem_wdata <= bus.ls_wdata;
            owner_ls      <= 1'b1;
            streak        <= bus.if_req ? streak + 4'd1 : '0;
            state         <= BUSY;
          end else if (if_win) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= '0;
            owner_ls      <= 1'b0;
            streak        <= '0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          // A mem_ack coinciding with expiry takes precedence and counts as success
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (!bus.mem_we) begin
              if (owner_ls) bus.ls_rdata <= bus.mem_rdata;
              else          bus.if_rdata <= bus.mem_rdata;
            end
            bus.ls_ack <= owner_ls;
            bus.if_ack <= !owner_ls;
            state      <= RESP;
          end else if (TIMEOUT_CYCLES != 0 && tcnt == TO_LAST) begin
            bus.mem_req <= 1'b0;
            if (!bus.mem_we) begin
              if (owner_ls) bus.ls_rdata <= 32'hDEADBEEF;
              else          bus.if_rdata <= 32'hDEADBEEF;
            end
            bus.ls_ack  <= owner_ls;
            bus.if_ack  <= !owner_ls;
            bus.timeout <= 1'b1;
            state       <= RESP;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        RESP: begin
          bus.if_ack  <= 1'b0;
          bus.ls_ack  <= 1'b0;
          bus.timeout <= 1'b0;
          tcnt        <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_COUNTERS_EN
  logic if_stall;
  logic ls_stall;

  // Outside IDLE the latched owner is the only requester not counted as stalled
  assign if_stall = bus.if_req && !(state != IDLE && !owner_ls);
  assign ls_stall = bus.ls_req && !(state != IDLE && owner_ls);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_if_grants    <= '0;
      perf_ls_grants    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (if_win)               perf_if_grants    <= perf_if_grants + 32'd1;
      if (ls_win)               perf_ls_grants    <= perf_ls_grants + 32'd1;
      if (if_stall || ls_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`else
  // Counters absent; arbitration above is unchanged.
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter (MAX_LS_STREAK=4, TIMEOUT_CYCLES=8).
module tb_mem_bus_arbiter;
  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_if_g = 0;
  int   exp_ls_g = 0;

  mem_bus_arbiter_if bus();

`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] perf_if_grants, perf_ls_grants, perf_stall_cycles;
`endif

  mem_bus_arbiter #(.MAX_LS_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
`ifdef ARB_PERF_COUNTERS_EN
    .perf_if_grants    (perf_if_grants),
    .perf_ls_grants    (perf_ls_grants),
    .perf_stall_cycles (perf_stall_cycles),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_data;
    int unsigned delay;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_ls_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge with the arbiter in IDLE.
  task automatic do_txn(input vec_t v);
    if (v.is_ls) begin
      bus.ls_req = 1'b1; bus.ls_we = v.we; bus.ls_addr = v.addr; bus.ls_wdata = v.wdata;
      exp_ls_g++;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
      exp_if_g++;
    end
    @(negedge clk);
    chk("txn_mem_req", {31'b0, bus.mem_req}, 32'd1);
    chk("txn_mem_addr", bus.mem_addr, v.addr);
    chk("txn_mem_we", {31'b0, bus.mem_we}, {31'b0, v.is_ls & v.we});
    if (v.is_ls && v.we) chk("txn_mem_wdata", bus.mem_wdata, v.wdata);
    repeat (v.delay) @(negedge clk);
    chk("txn_req_held", {31'b0, bus.mem_req}, 32'd1);
    bus.mem_ack = 1'b1; bus.mem_rdata = v.mem_data;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("txn_if_ack", {31'b0, bus.if_ack}, {31'b0, !v.is_ls});
    chk("txn_ls_ack", {31'b0, bus.ls_ack}, {31'b0, v.is_ls});
    chk("txn_timeout", {31'b0, bus.timeout}, 32'd0);
    chk("txn_req_drop", {31'b0, bus.mem_req}, 32'd0);
    chk("txn_if_rdata", bus.if_rdata, v.exp_if_rdata);
    chk("txn_ls_rdata", bus.ls_rdata, v.exp_ls_rdata);
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    @(negedge clk);
    chk("txn_ack_pulse", {30'b0, bus.if_ack, bus.ls_ack}, 32'd0);
  endtask

  initial begin
    int unsigned hi;
    logic [5:0]  fair_exp;
    logic        granted_ls;

    vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        32'h00A00093, 0, 32'h00A00093, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h200, 32'h55,       32'h77777777, 2, 32'h00A00093, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h204, 32'h0,        32'h12345678, 1, 32'h00A00093, 32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 32'h14,  32'h0,        32'hCAFEF00D, 3, 32'hCAFEF00D, 32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 32'h208, 32'hFFFFFFFF, 32'hBAD0BAD0, 0, 32'hCAFEF00D, 32'h12345678};
    vecs[5] = '{1'b0, 1'b0, 32'h80,  32'h0,        32'h0000CAFE, 0, 32'h0000CAFE, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h84,  32'h0,        32'h00001234, 1, 32'h0000CAFE, 32'h00001234};
    vecs[7] = '{1'b0, 1'b0, 32'h88,  32'h0,        32'h0000BEEF, 0, 32'h0000BEEF, 32'h00001234};
    vecs[8] = '{1'b1, 1'b1, 32'h8C,  32'hA5A5A5A5, 32'h99999999, 0, 32'h0000BEEF, 32'h00001234};
    vecs[9] = '{1'b0, 1'b0, 32'h90,  32'h0,        32'h00000001, 2, 32'h00000001, 32'h00001234};

    reset = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
    chk("rst_acks", {29'b0, bus.if_ack, bus.ls_ack, bus.timeout}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) do_txn(vecs[i]);

    // mem_ack while IDLE must have no effect
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h11111111;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_req", {31'b0, bus.mem_req}, 32'd0);
    chk("idle_ack_acks", {30'b0, bus.if_ack, bus.ls_ack}, 32'd0);
    chk("idle_ack_if_rdata", bus.if_rdata, 32'hCAFEF00D);
    chk("idle_ack_ls_rdata", bus.ls_rdata, 32'h12345678);

    // Simultaneous requests: load/store write first, then fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h200; bus.ls_wdata = 32'h55;
    @(negedge clk);
    chk("sim_first_addr", bus.mem_addr, 32'h200);
    chk("sim_first_we", {31'b0, bus.mem_we}, 32'd1);
    chk("sim_first_wdata", bus.mem_wdata, 32'h55);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("sim_ls_ack", {30'b0, bus.if_ack, bus.ls_ack}, 32'd1);
    bus.ls_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sim_second_addr", bus.mem_addr, 32'h40);
    chk("sim_second_we", {31'b0, bus.mem_we}, 32'd0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h777;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("sim_if_ack", {30'b0, bus.if_ack, bus.ls_ack}, 32'd2);
    chk("sim_if_rdata", bus.if_rdata, 32'h777);
    bus.if_req = 1'b0;
    @(negedge clk);

    // Fairness: both held, expect LS x4, IF, LS
    fair_exp = 6'b101111;
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h2000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("fair_req", {31'b0, bus.mem_req}, 32'd1);
      granted_ls = (bus.mem_addr == 32'h2000);
      chk("fair_owner", {31'b0, granted_ls}, {31'b0, fair_exp[i]});
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hF0000000 + 32'(i);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      chk("fair_ack", {30'b0, bus.if_ack, bus.ls_ack}, granted_ls ? 32'd1 : 32'd2);
      @(negedge clk);
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    @(negedge clk);

    // Timeout on an LS read that memory never acknowledges
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h300;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.mem_req) hi++;
      else break;
    end
    chk("to_req_cycles", hi, 32'd8);
    chk("to_ls_ack", {31'b0, bus.ls_ack}, 32'd1);
    chk("to_flag", {31'b0, bus.timeout}, 32'd1);
    chk("to_rdata", bus.ls_rdata, 32'hDEADBEEF);
    chk("to_if_ack", {31'b0, bus.if_ack}, 32'd0);
    bus.ls_req = 1'b0;
    @(negedge clk);
    chk("to_flag_pulse", {30'b0, bus.timeout, bus.ls_ack}, 32'd0);

    // mem_ack in the expiry cycle counts as success
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h304;
    repeat (8) @(negedge clk);
    chk("late_req_held", {31'b0, bus.mem_req}, 32'd1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADC0DE;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("late_ls_ack", {31'b0, bus.ls_ack}, 32'd1);
    chk("late_no_timeout", {31'b0, bus.timeout}, 32'd0);
    chk("late_rdata", bus.ls_rdata, 32'h0BADC0DE);
    bus.ls_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset in BUSY
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    @(negedge clk);
    chk("arst_busy", {31'b0, bus.mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_req_drop", {31'b0, bus.mem_req}, 32'd0);
    chk("arst_mem_addr", bus.mem_addr, 32'd0);
    bus.if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("arst_no_ack", {30'b0, bus.if_ack, bus.ls_ack}, 32'd0);
    chk("arst_ls_rdata", bus.ls_rdata, 32'd0);
    reset = 1'b1;
    exp_if_g = 0; exp_ls_g = 0;

    for (int i = 5; i < 10; i++) do_txn(vecs[i]);

`ifdef ARB_PERF_COUNTERS_EN
    chk("perf_if_grants", perf_if_grants, 32'(exp_if_g));
    chk("perf_ls_grants", perf_ls_grants, 32'(exp_ls_g));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the CPU's single memory port between two requesters: the fetch stage (instruction reads) and a load/store unit (data reads/writes).
- Sits between the pipeline and the external memory interface.
- Latches the winning request, runs one memory transaction under a req/ack handshake, and returns data with a one-cycle ack pulse.
- Priority goes to load/store, with a fairness limit so fetch cannot starve. A timeout ends transactions that memory never acknowledges.

Parameters:
- MAX_LS_STREAK, 4, consecutive load/store grants allowed while if_req is pending before fetch is forced to win (legal range 1..15).
- TIMEOUT_CYCLES, 255, BUSY cycles without mem_ack before abort; 0 disables the timeout (legal range 0..255).

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- if_req  input  1  fetch read request; held until if_ack
- if_addr  input  32  fetch address; stable while if_req
- if_rdata  output  32  fetch read data; valid when if_ack=1
- if_ack  output  1  one-cycle completion pulse for fetch
- ls_req  input  1  load/store request; held until ls_ack
- ls_we  input  1  1 = write, 0 = read
- ls_addr  input  32  data address
- ls_wdata  input  32  write data
- ls_rdata  output  32  load data; valid when ls_ack=1 on a read
- ls_ack  output  1  one-cycle completion pulse for load/store
- mem_req  output  1  memory request; held until mem_ack
- mem_we  output  1  memory write enable
- mem_addr  output  32  memory address
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data; valid with mem_ack
- mem_ack  input  1  memory completion, one cycle
- timeout  output  1  pulses together with the ack of an aborted transaction

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output 0; streak counter 0; timeout counter 0. A transaction in flight is abandoned and mem_req drops immediately.
- IDLE: request inputs are sampled on each edge.
  - If ls_req=1 and not (if_req=1 and streak==MAX_LS_STREAK): grant LS. Increment streak if if_req=1, else clear it.
  - Otherwise, if if_req=1: grant IF and clear streak.
  - On a grant: latch addr, we (0 for IF), wdata and the owner into mem_* registers, then go to BUSY.
- BUSY:
  - mem_req=1; mem_* outputs stay stable.
  - On mem_ack=1: capture mem_rdata into the owner's rdata register (not for writes), drop mem_req, go to RESP.
  - Timeout counter increments each BUSY cycle. If it reaches TIMEOUT_CYCLES (nonzero) with no mem_ack: drop mem_req, set rdata to 32'hDEADBEEF for a read, raise timeout, go to RESP.
- RESP:
  - Owner's ack=1 for exactly one cycle; timeout=1 only if this transaction was aborted.
  - Request inputs are ignored this cycle.
  - Next state is IDLE and the timeout counter clears.
- Latency: a request first seen in IDLE in cycle 0 gives mem_req in cycles 1..k, where mem_ack arrives in cycle k. The ack pulse is in cycle k+1. Minimum is 2 cycles; back-to-back throughput is one transaction per 3 cycles.
- Requesters: drop req (or present a new request) in the cycle after ack. A req still high in IDLE is treated as a new transaction.
- if_rdata and ls_rdata keep their last value between acks; a write does not change ls_rdata.
- mem_ack in IDLE or RESP is ignored.
- A mem_ack in the same cycle the timeout expires counts as success: the data is captured and timeout=0.

Optional Feature:
- ARB_PERF_COUNTERS_EN defined: adds outputs perf_if_grants[31:0], perf_ls_grants[31:0] and perf_stall_cycles[31:0].
  - Each grant counter increments on its grant.
  - perf_stall_cycles increments every cycle in which a requester has req=1 but is not the current owner.
  - All three wrap at 2^32 and clear on reset.
- Not defined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10, memory acks in cycle 1 with 0x00A00093 -> mem_addr=0x10, mem_we=0; if_ack in cycle 2 with if_rdata=0x00A00093; ls_ack stays 0.
- Simultaneous requests: if_req and ls_req together in IDLE, ls_we=1, ls_addr=0x200, ls_wdata=0x55 -> LS granted first (mem_we=1, mem_wdata=0x55); after ls_ack, IF granted at the next IDLE.
- Fairness: ls_req held high with if_req pending, MAX_LS_STREAK=4 -> exactly 4 LS grants, then an IF grant, then LS again.
- Timeout: TIMEOUT_CYCLES=8, memory never acks on an LS read -> mem_req high for 8 cycles then low; ls_ack=1, timeout=1, ls_rdata=0xDEADBEEF.
- Reset mid-transaction: reset goes low while in BUSY -> mem_req=0 asynchronously with no ack. After release, a new if_req completes normally.
- With ARB_PERF_COUNTERS_EN defined: 3 IF and 2 LS transactions -> perf_if_grants=3, perf_ls_grants=2; perf_stall_cycles matches the cycles in which a req was pending but not owned.
